// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: requests words from instruction memory at the PC and
// hands them to decode. Define FETCH_PERF_CNT_EN to add the stall_cnt output.
module fetch_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_out,
  output logic        en_pc,
  output logic [31:0] pc_in,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] stall_cnt,
`endif
  input  logic        id_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} state_e;

  state_e      state_q, state_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_valid_q <= 1'b0;
      if_instr_q <= '0;
      if_pc_q    <= '0;
      pend_pc_q  <= '0;
    end else begin
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      pend_pc_q  <= pend_pc_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no latches are inferred.
  always_comb begin
    state_d    = state_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    pend_pc_d  = pend_pc_q;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_ack) begin
          if (!redirect) begin
            if_valid_d = 1'b1;
            if_instr_d = imem_rdata;
            if_pc_d    = pc_out;
            state_d    = HOLD;
          end
        end else if (redirect) begin
          pend_pc_d = redirect_pc;
          state_d   = DROP;
        end
      end
      HOLD: begin
        if (redirect || id_ready) begin
          if_valid_d = 1'b0;
          state_d    = REQ;
        end
      end
      DROP: begin
        // The in-flight word belongs to the old path; wait it out, keeping the latest target.
        if (imem_ack) begin
          state_d = REQ;
        end else if (redirect) begin
          pend_pc_d = redirect_pc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    en_pc    = 1'b0;
    pc_in    = pc_out + 32'd1;
    imem_req = 1'b0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (redirect) begin
            en_pc = 1'b1;
            pc_in = redirect_pc;
          end
        end
        REQ: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            en_pc = 1'b1;
            if (redirect) pc_in = redirect_pc;
          end
        end
        HOLD: begin
          if (redirect) begin
            en_pc = 1'b1;
            pc_in = redirect_pc;
          end
        end
        DROP: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            en_pc = 1'b1;
            pc_in = redirect ? redirect_pc : pend_pc_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_addr = pc_out;
  assign if_valid  = if_valid_q;
  assign if_instr  = if_instr_q;
  assign if_pc     = if_pc_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((imem_req && !imem_ack) || (state_q == HOLD && !id_ready)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a small PC register and address-derived memory data.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_out;
  logic        en_pc;
  logic [31:0] pc_in;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  fetch_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .pc_out      (pc_out),
    .en_pc       (en_pc),
    .pc_in       (pc_in),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
`ifdef FETCH_PERF_CNT_EN
    .stall_cnt   (stall_cnt),
`endif
    .id_ready    (id_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  always #5 clk = ~clk;

  // External PC register, reset by the same rst.
  always_ff @(posedge clk) begin
    if (rst) pc_out <= '0;
    else if (en_pc) pc_out <= pc_in;
  end

  assign imem_rdata = pc_out ^ 32'hDEAD_0000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set(input logic ack, input logic rdy, input logic rd, input logic [31:0] rpc);
    imem_ack    = ack;
    id_ready    = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    set(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (3) tick();
    check("rst_en_pc", en_pc, 0);
    check("rst_imem_req", imem_req, 0);
    check("rst_if_valid", if_valid, 0);
    check("rst_if_pc", if_pc, 0);
    check("rst_if_instr", if_instr, 0);
`ifdef FETCH_PERF_CNT_EN
    check("rst_stall_cnt", stall_cnt, 0);
`endif

    // Reset release, ack every request cycle
    rst = 1'b0;
    #1;
    check("idle_imem_req", imem_req, 0);
    check("idle_en_pc", en_pc, 0);
    tick();
    check("c2_imem_req", imem_req, 1);
    check("c2_addr", imem_addr, 32'h0);
    check("c2_en_pc", en_pc, 1);
    check("c2_pc_in", pc_in, 32'h1);
    check("c2_if_valid", if_valid, 0);
    tick();
    check("c3_if_valid", if_valid, 1);
    check("c3_if_pc", if_pc, 32'h0);
    check("c3_if_instr", if_instr, 32'hDEAD_0000);

    // Decode stalls for 5 cycles
    for (int i = 0; i < 5; i++) begin
      check("stall_if_instr", if_instr, 32'hDEAD_0000);
      check("stall_if_pc", if_pc, 32'h0);
      check("stall_if_valid", if_valid, 1);
      check("stall_imem_req", imem_req, 0);
      check("stall_en_pc", en_pc, 0);
      tick();
    end
    set(1'b1, 1'b1, 1'b0, 32'h0);
    check("accept_en_pc", en_pc, 0);
    tick();
    check("accept_if_valid", if_valid, 0);
    check("accept_addr", imem_addr, 32'h1);

    // Memory answers after 3 wait cycles
    set(1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      check("wait_addr", imem_addr, 32'h1);
      check("wait_en_pc", en_pc, 0);
      check("wait_imem_req", imem_req, 1);
      tick();
    end
    set(1'b1, 1'b0, 1'b0, 32'h0);
    check("ack_addr", imem_addr, 32'h1);
    check("ack_en_pc", en_pc, 1);
    check("ack_pc_in", pc_in, 32'h2);
    tick();
    check("late_if_instr", if_instr, 32'hDEAD_0001);
    check("late_if_pc", if_pc, 32'h1);
    check("late_if_valid", if_valid, 1);

    // Redirect in HOLD together with id_ready
    set(1'b0, 1'b1, 1'b1, 32'h40);
    check("hold_rd_en_pc", en_pc, 1);
    check("hold_rd_pc_in", pc_in, 32'h40);
    tick();
    set(1'b0, 1'b0, 1'b0, 32'h0);
    check("hold_rd_if_valid", if_valid, 0);
    check("hold_rd_addr", imem_addr, 32'h40);
    check("hold_rd_imem_req", imem_req, 1);

    // Two redirects while a request is outstanding
    set(1'b0, 1'b0, 1'b1, 32'h80);
    check("req_rd_en_pc", en_pc, 0);
    check("req_rd_imem_req", imem_req, 1);
    tick();
    set(1'b0, 1'b0, 1'b1, 32'h90);
    check("drop_imem_req", imem_req, 1);
    check("drop_addr", imem_addr, 32'h40);
    check("drop_en_pc", en_pc, 0);
    check("drop_if_valid", if_valid, 0);
    tick();
    set(1'b1, 1'b0, 1'b0, 32'h0);
    check("drop_ack_en_pc", en_pc, 1);
    check("drop_ack_pc_in", pc_in, 32'h90);
    tick();
    check("post_drop_addr", imem_addr, 32'h90);
    check("post_drop_if_valid", if_valid, 0);
    check("post_drop_pc_in", pc_in, 32'h91);
    tick();
    check("post_drop_if_pc", if_pc, 32'h90);
    check("post_drop_if_instr", if_instr, 32'hDEAD_0090);

    // PC wrap-around
    set(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    check("wrap_rd_pc_in", pc_in, 32'hFFFF_FFFF);
    tick();
    set(1'b1, 1'b0, 1'b0, 32'h0);
    check("wrap_addr", imem_addr, 32'hFFFF_FFFF);
    check("wrap_en_pc", en_pc, 1);
    check("wrap_pc_in", pc_in, 32'h0);
    tick();
    check("wrap_if_pc", if_pc, 32'hFFFF_FFFF);
    check("wrap_next_addr", imem_addr, 32'h0);

    // Redirect coincident with ack in REQ: data discarded, stay in REQ
    set(1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    set(1'b1, 1'b0, 1'b1, 32'h20);
    check("req_rdack_en_pc", en_pc, 1);
    check("req_rdack_pc_in", pc_in, 32'h20);
    tick();
    set(1'b0, 1'b0, 1'b0, 32'h0);
    check("req_rdack_imem_req", imem_req, 1);
    check("req_rdack_if_valid", if_valid, 0);
    check("req_rdack_addr", imem_addr, 32'h20);

    // Redirect coincident with ack in DROP wins over the pending target
    set(1'b0, 1'b0, 1'b1, 32'h30);
    tick();
    set(1'b1, 1'b0, 1'b1, 32'h50);
    check("drop_rdack_pc_in", pc_in, 32'h50);
    tick();
    set(1'b0, 1'b0, 1'b0, 32'h0);
    check("drop_rdack_addr", imem_addr, 32'h50);

    // Reset in the middle of a request
    rst = 1'b1;
    #1;
    check("mid_rst_en_pc", en_pc, 0);
    check("mid_rst_imem_req", imem_req, 0);
    tick();
    rst = 1'b0;
    set(1'b1, 1'b0, 1'b0, 32'h0);
    check("after_rst_imem_req", imem_req, 0);
    check("after_rst_en_pc", en_pc, 0);
    check("after_rst_if_valid", if_valid, 0);
    check("after_rst_addr", imem_addr, 32'h0);
    tick();
    check("after_rst_req_pc_in", pc_in, 32'h1);
    tick();
    check("after_rst_if_pc", if_pc, 32'h0);
    check("after_rst_if_valid2", if_valid, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
